// File: rtl/palindrome_nb_stream.sv
// Purpose : serial bit-stream palindrome detector, window length chosen at runtime via len_i.
// Latency : palindrome_o pulses exactly 1 clk after the accepted bit that closes a palindrome.
// Backpr. : none; every valid_i bit is consumed, and idle cycles freeze all state.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   clear_i           synchronous restart (drops history and count; beats valid_i)
//   valid_i, x_i      qualified serial input bit
//   len_i             window length, legal 2..MAX_LEN; other values never match
//   palindrome_o      1-cycle match pulse
//   match_cnt_o       saturating count of palindrome_o pulses
module palindrome_nb_stream #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             x_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             palindrome_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    localparam int                FILL_W   = $clog2(MAX_LEN);
    localparam int                SEL_N    = 1 << LEN_W;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);

    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-2:0] hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic               accept;
    logic [MAX_LEN-1:0] win;
    logic [SEL_N-1:0]   sym;
    logic               len_ok;
    logic               fill_ok;
    logic               hit;

    assign accept = valid_i & ~clear_i;

    // win[0] is the incoming bit, win[k] the k-th most recent accepted bit.
    assign win = {hist_q, x_i};

    always_comb begin
        hist_d    = '0;
        hist_d[0] = x_i;
        for (int i = 1; i < MAX_LEN - 1; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

    // Symmetry is evaluated for every legal length in parallel and the
    // requested one is selected afterwards; this keeps all bit selects
    // constant. Entries for illegal lengths stay 0.
    always_comb begin
        sym = '0;
        for (int l = 2; l <= MAX_LEN; l++) begin
            sym[l] = 1'b1;
            for (int k = 0; k < l / 2; k++) begin
                if (win[k] != win[l-1-k]) begin
                    sym[l] = 1'b0;
                end
            end
        end
    end

    assign len_ok  = (len_i >= LEN_W'(2)) && (len_i <= LEN_W'(MAX_LEN));
    // A window of L bits needs L-1 bits already in history.
    assign fill_ok = (32'(fill_q) + 32'd1) >= 32'(len_i);
    assign hit     = len_ok & fill_ok & sym[len_i];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q       <= '0;
            fill_q       <= '0;
            palindrome_o <= 1'b0;
            match_cnt_o  <= '0;
        end else if (clear_i) begin
            hist_q       <= '0;
            fill_q       <= '0;
            palindrome_o <= 1'b0;
            match_cnt_o  <= '0;
        end else begin
            palindrome_o <= accept & hit;
            if (accept) begin
                hist_q <= hist_d;
                if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + 1'b1;
                end
                if (hit && (match_cnt_o != {CNT_W{1'b1}})) begin
                    match_cnt_o <= match_cnt_o + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_palindrome_nb_stream.sv
module tb_palindrome_nb_stream;

    logic        clk;
    logic        reset;
    logic        clear_i;
    logic        valid_i;
    logic        x_i;
    logic [3:0]  len_i;
    logic        pal;
    logic [15:0] cnt;
    logic        pal2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    palindrome_nb_stream #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .x_i          (x_i),
        .len_i        (len_i),
        .palindrome_o (pal),
        .match_cnt_o  (cnt)
    );

    // Narrow-counter instance sharing the same stimulus, used for saturation.
    palindrome_nb_stream #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .x_i          (x_i),
        .len_i        (len_i),
        .palindrome_o (pal2),
        .match_cnt_o  (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one accepted bit; returns 1 time unit after the capturing edge.
    task automatic send(input logic b);
        @(negedge clk);
        valid_i = 1'b1;
        x_i     = b;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_i = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    logic [7:0] t3_bits;
    logic [7:0] t3_exp;
    logic [3:0] t4_len [3];
    int         t5_cnt [6];
    logic [5:0] t5_pal;

    initial begin
        reset   = 1'b1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        x_i     = 1'b0;
        len_i   = 4'd3;
        #12;
        chk("reset_pal", 32'(pal), 0);
        chk("reset_cnt", 32'(cnt), 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: len 3, bits 1,0,1
        len_i = 4'd3;
        send(1'b1); chk("t1_b1_pal", 32'(pal), 0);
        send(1'b0); chk("t1_b2_pal", 32'(pal), 0);
        send(1'b1); chk("t1_b3_pal", 32'(pal), 1);
        chk("t1_cnt", 32'(cnt), 1);
        idle(1);    chk("t1_pulse_width", 32'(pal), 0);

        // 2: len 4, bits 1,0,0,1 with two idle cycles between bits
        do_clear();
        chk("t2_clr_cnt", 32'(cnt), 0);
        len_i = 4'd4;
        send(1'b1); chk("t2_b1_pal", 32'(pal), 0);
        idle(2);
        send(1'b0); chk("t2_b2_pal", 32'(pal), 0);
        idle(2);
        send(1'b0); chk("t2_b3_pal", 32'(pal), 0);
        idle(2);    chk("t2_gap_pal", 32'(pal), 0);
        send(1'b1); chk("t2_b4_pal", 32'(pal), 1);
        idle(2);    chk("t2_after_pal", 32'(pal), 0);
        chk("t2_cnt", 32'(cnt), 1);

        // 3: len 5, bits 1,1,0,1,1,0,1,1; hits on bits 5 and 8
        do_clear();
        len_i   = 4'd5;
        t3_bits = 8'b1101_1011;
        t3_exp  = 8'b1001_0000;
        for (int i = 0; i < 8; i++) begin
            send(t3_bits[i]);
            chk($sformatf("t3_b%0d_pal", i + 1), 32'(pal), 32'(t3_exp[i]));
        end
        chk("t3_cnt", 32'(cnt), 2);
        len_i = 4'd2;
        send(1'b1); chk("t3_len2_pal", 32'(pal), 1);
        chk("t3_len2_cnt", 32'(cnt), 3);

        // 4: illegal lengths never match
        do_clear();
        t4_len = '{4'd1, 4'd0, 4'd9};
        for (int j = 0; j < 3; j++) begin
            len_i = t4_len[j];
            for (int i = 0; i < 4; i++) begin
                send(1'b1);
                chk($sformatf("t4_len%0d_b%0d_pal", t4_len[j], i + 1), 32'(pal), 0);
            end
        end
        chk("t4_cnt", 32'(cnt), 0);

        // 5: saturation on the 2-bit counter instance
        do_clear();
        len_i  = 4'd2;
        t5_cnt = '{0, 1, 2, 3, 3, 3};
        t5_pal = 6'b111110;
        for (int i = 0; i < 6; i++) begin
            send(1'b1);
            chk($sformatf("t5_b%0d_pal", i + 1), 32'(pal2), 32'(t5_pal[i]));
            chk($sformatf("t5_b%0d_cnt", i + 1), 32'(cnt2), 32'(t5_cnt[i]));
        end
        chk("t5_wide_cnt", 32'(cnt), 5);

        // 6: clear with valid drops the bit; history and count restart
        do_clear();
        len_i = 4'd3;
        send(1'b1);
        send(1'b0);
        send(1'b1);
        chk("t6_pre_cnt", 32'(cnt), 1);
        @(negedge clk);
        clear_i = 1'b1;
        valid_i = 1'b1;
        x_i     = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        chk("t6_clr_pal", 32'(pal), 0);
        chk("t6_clr_cnt", 32'(cnt), 0);
        send(1'b0); chk("t6_b1_pal", 32'(pal), 0);
        send(1'b1); chk("t6_b2_pal", 32'(pal), 0);
        send(1'b0); chk("t6_b3_pal", 32'(pal), 1);
        chk("t6_cnt", 32'(cnt), 1);
        send(1'b1); chk("t6_b4_pal", 32'(pal), 1);
        chk("t6_b4_cnt", 32'(cnt), 2);

        // Async reset between edges clears outputs immediately
        #2;
        reset = 1'b1;
        #1;
        chk("t6_arst_pal", 32'(pal), 0);
        chk("t6_arst_cnt", 32'(cnt), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(1'b0); chk("t6_post_b1_pal", 32'(pal), 0);
        send(1'b1); chk("t6_post_b2_pal", 32'(pal), 0);
        send(1'b0); chk("t6_post_b3_pal", 32'(pal), 1);
        chk("t6_post_cnt", 32'(cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
